// File: rtl/midi_rx_parser.sv
// MIDI receiver: oversampling UART deserialiser plus Note-On/Note-Off parser with running status.
// Define MIDI_RX_ERR_COUNT_EN to build the saturating framing-error counter on ERR_COUNT.
module midi_rx_parser #(
  parameter int CLKS_PER_BIT = 128,
  parameter int OMNI         = 0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DATA,
  input  logic [3:0] CH_SEL,
  output logic       MSG_VALID,
  output logic       NOTE_ON,
  output logic [3:0] CHANNEL,
  output logic [6:0] NOTE,
  output logic [6:0] VELOCITY,
  output logic       FRAME_ERR,
  output logic [7:0] LED,
  output logic [7:0] ERR_COUNT
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LP_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LP_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_WAIT_D1, P_WAIT_D2} p_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Synchroniser clears to 0 so a line held low across reset never looks like a start edge.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_d;
  logic                   w_rx;
  logic                   w_fall;

  assign w_rx   = r_sync[SYNC_STAGES-1];
  assign w_fall = r_rx_d & ~w_rx;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync <= '0;
      r_rx_d <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], DATA};
      r_rx_d <= w_rx;
    end
  end

  // Deserialiser stage
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_byte_rdy;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rx_state <= RX_IDLE;
      r_cnt      <= '0;
      r_bit      <= 3'd0;
      r_shift    <= 8'd0;
      r_byte_rdy <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      r_byte_rdy <= 1'b0;
      FRAME_ERR  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= 3'd0;
          if (w_fall) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == LP_HALF_M1) begin
            r_cnt      <= '0;
            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == LP_FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_bit      <= 3'd0;
              r_rx_state <= RX_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == LP_FULL_M1) begin
            r_cnt      <= '0;
            r_rx_state <= RX_IDLE;
            if (w_rx) r_byte_rdy <= 1'b1;
            else      FRAME_ERR  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Parser stage
  p_state_t   r_pstate;
  logic       r_rs_valid;
  logic       r_rs_note;
  logic       r_rs_on;
  logic [3:0] r_rs_chan;
  logic [6:0] r_d1;
  logic       w_ch_match;
  logic       w_emit_on;

  assign w_ch_match = (OMNI != 0) || (r_rs_chan == CH_SEL);
  assign w_emit_on  = r_rs_on && (r_shift[6:0] != 7'd0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pstate   <= P_IDLE;
      r_rs_valid <= 1'b0;
      r_rs_note  <= 1'b0;
      r_rs_on    <= 1'b0;
      r_rs_chan  <= 4'd0;
      r_d1       <= 7'd0;
      MSG_VALID  <= 1'b0;
      NOTE_ON    <= 1'b0;
      CHANNEL    <= 4'd0;
      NOTE       <= 7'd0;
      VELOCITY   <= 7'd0;
      LED        <= 8'd0;
    end else begin
      MSG_VALID <= 1'b0;
      if (FRAME_ERR) begin
        r_rs_valid <= 1'b0;
        r_pstate   <= P_IDLE;
      end else if (r_byte_rdy) begin
        if (r_shift[7]) begin
          if (r_shift[7:3] == 5'b11111) begin
            r_pstate <= r_pstate;
          end else if (r_shift[7:4] == 4'hF) begin
            r_rs_valid <= 1'b0;
            r_pstate   <= P_IDLE;
          end else begin
            // 0x8n/0x9n are decoded; 0xAn..0xEn only swallow their data bytes.
            r_rs_valid <= 1'b1;
            r_rs_note  <= (r_shift[6:5] == 2'b00);
            r_rs_on    <= r_shift[4];
            r_rs_chan  <= r_shift[3:0];
            r_pstate   <= P_WAIT_D1;
          end
        end else begin
          case (r_pstate)
            P_IDLE: begin
              if (r_rs_valid) begin
                r_d1     <= r_shift[6:0];
                r_pstate <= P_WAIT_D2;
              end
            end
            P_WAIT_D1: begin
              r_d1     <= r_shift[6:0];
              r_pstate <= P_WAIT_D2;
            end
            P_WAIT_D2: begin
              r_pstate <= P_WAIT_D1;
              if (r_rs_note && w_ch_match) begin
                MSG_VALID <= 1'b1;
                NOTE_ON   <= w_emit_on;
                CHANNEL   <= r_rs_chan;
                NOTE      <= r_d1;
                VELOCITY  <= r_shift[6:0];
                if (w_emit_on)              LED <= {1'b1, r_d1};
                else if (r_d1 == LED[6:0])  LED <= 8'd0;
              end
            end
            default: r_pstate <= P_IDLE;
          endcase
        end
      end
    end
  end

`ifdef MIDI_RX_ERR_COUNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          r_err_cnt <= 8'd0;
    else if (FRAME_ERR) r_err_cnt <= sat_inc8(r_err_cnt);
  end

  assign ERR_COUNT = r_err_cnt;
`else
  assign ERR_COUNT = 8'd0;
`endif

endmodule

// File: tb/tb_midi_rx_parser.sv
// Scoreboard bench for midi_rx_parser: one OMNI instance and one channel-filtered instance.
`timescale 1ns/1ps
module tb_midi_rx_parser;
  localparam int CPB = 16;
`ifdef MIDI_RX_ERR_COUNT_EN
  localparam logic [7:0] EXP_EC = 8'd1;
`else
  localparam logic [7:0] EXP_EC = 8'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx  = 1'b1;
  logic sel = 1'b0;
  logic data_a, data_b;
  assign data_a = sel ? 1'b1 : tx;
  assign data_b = sel ? tx : 1'b1;

  always #5 clk = ~clk;

  logic       mv_a, on_a, fe_a, mv_b, on_b, fe_b;
  logic [3:0] ch_a, ch_b;
  logic [6:0] note_a, vel_a, note_b, vel_b;
  logic [7:0] led_a, ec_a, led_b, ec_b;

  midi_rx_parser #(.CLKS_PER_BIT(CPB), .OMNI(1), .SYNC_STAGES(2)) dut_a (
    .CLK(clk), .RESET(rst), .DATA(data_a), .CH_SEL(4'd0),
    .MSG_VALID(mv_a), .NOTE_ON(on_a), .CHANNEL(ch_a), .NOTE(note_a),
    .VELOCITY(vel_a), .FRAME_ERR(fe_a), .LED(led_a), .ERR_COUNT(ec_a));

  midi_rx_parser #(.CLKS_PER_BIT(CPB), .OMNI(0), .SYNC_STAGES(2)) dut_b (
    .CLK(clk), .RESET(rst), .DATA(data_b), .CH_SEL(4'd3),
    .MSG_VALID(mv_b), .NOTE_ON(on_b), .CHANNEL(ch_b), .NOTE(note_b),
    .VELOCITY(vel_b), .FRAME_ERR(fe_b), .LED(led_b), .ERR_COUNT(ec_b));

  typedef struct packed {
    logic       on;
    logic [3:0] ch;
    logic [6:0] note;
    logic [6:0] vel;
    logic [7:0] led;
  } msg_t;

  msg_t       qa[$];
  msg_t       qb[$];
  msg_t       last_a;
  logic [7:0] led_m_a = 8'd0;
  logic [7:0] led_m_b = 8'd0;
  int         pass_cnt = 0;
  int         total = 0;
  int         fe_cnt_a = 0;

  task automatic tick();
    msg_t e;
    @(negedge clk);
    if (mv_a) begin
      total++;
      if (qa.size() == 0) begin
        $display("FAIL msg_a_unexpected: got %h, required no message", {on_a, ch_a, note_a, vel_a, led_a});
      end else begin
        e = qa.pop_front();
        if ({on_a, ch_a, note_a, vel_a, led_a} !== e)
          $display("FAIL msg_a: got %h, required %h", {on_a, ch_a, note_a, vel_a, led_a}, e);
        else pass_cnt++;
      end
    end
    if (mv_b) begin
      total++;
      if (qb.size() == 0) begin
        $display("FAIL msg_b_unexpected: got %h, required no message", {on_b, ch_b, note_b, vel_b, led_b});
      end else begin
        e = qb.pop_front();
        if ({on_b, ch_b, note_b, vel_b, led_b} !== e)
          $display("FAIL msg_b: got %h, required %h", {on_b, ch_b, note_b, vel_b, led_b}, e);
        else pass_cnt++;
      end
    end
    if (fe_a) fe_cnt_a++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic s, input logic [7:0] b, input logic stop_ok, input int abort_at);
    sel = s;
    tx  = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      tx = b[i];
      if (i == abort_at) begin
        idle(CPB / 2);
        return;
      end
      idle(CPB);
    end
    tx = stop_ok;
    idle(CPB);
    tx = 1'b1;
    if (!stop_ok) idle(CPB);
  endtask

  task automatic push(input logic s, input logic st_on, input logic [3:0] ch,
                      input logic [6:0] note, input logic [6:0] vel);
    msg_t m;
    logic on;
    on = st_on && (vel != 7'd0);
    if (s == 1'b0) begin
      if (on) led_m_a = {1'b1, note};
      else if (note == led_m_a[6:0]) led_m_a = 8'd0;
      m = '{on: on, ch: ch, note: note, vel: vel, led: led_m_a};
      qa.push_back(m);
      last_a = m;
    end else begin
      if (on) led_m_b = {1'b1, note};
      else if (note == led_m_b[6:0]) led_m_b = 8'd0;
      m = '{on: on, ch: ch, note: note, vel: vel, led: led_m_b};
      qb.push_back(m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    total++;
    if ({mv_a, on_a, ch_a, note_a, vel_a, fe_a, led_a, ec_a} !== 38'd0)
      $display("FAIL reset_a: got %h, required 0", {mv_a, on_a, ch_a, note_a, vel_a, fe_a, led_a, ec_a});
    else pass_cnt++;
    total++;
    if ({mv_b, on_b, ch_b, note_b, vel_b, fe_b, led_b, ec_b} !== 38'd0)
      $display("FAIL reset_b: got %h, required 0", {mv_b, on_b, ch_b, note_b, vel_b, fe_b, led_b, ec_b});
    else pass_cnt++;
    rst = 1'b0;
    idle(20);
  endtask

  task automatic test_note_on();
    push(0, 1, 4'd0, 7'h3C, 7'h64);
    send_byte(0, 8'h90, 1, -1);
    send_byte(0, 8'h3C, 1, -1);
    send_byte(0, 8'h64, 1, -1);
    idle(40);
    total++;
    if (qa.size() != 0) $display("FAIL note_on_missing: got %0d pending, required 0", qa.size());
    else pass_cnt++;
    total++;
    if (led_a !== 8'hBC) $display("FAIL note_on_led: got %h, required bc", led_a);
    else pass_cnt++;
  endtask

  task automatic test_running_status();
    push(0, 1, 4'd0, 7'h3C, 7'h00);
    send_byte(0, 8'h3C, 1, -1);
    send_byte(0, 8'h00, 1, -1);
    idle(40);
    total++;
    if (qa.size() != 0) $display("FAIL running_missing: got %0d pending, required 0", qa.size());
    else pass_cnt++;
    total++;
    if (led_a !== 8'h00) $display("FAIL running_led: got %h, required 00", led_a);
    else pass_cnt++;
  endtask

  task automatic test_realtime();
    push(0, 1, 4'd1, 7'h40, 7'h7F);
    send_byte(0, 8'h91, 1, -1);
    send_byte(0, 8'h40, 1, -1);
    send_byte(0, 8'hF8, 1, -1);
    send_byte(0, 8'h7F, 1, -1);
    idle(40);
    total++;
    if (qa.size() != 0) $display("FAIL realtime_missing: got %0d pending, required 0", qa.size());
    else pass_cnt++;
    total++;
    if (ch_a !== 4'd1) $display("FAIL realtime_channel: got %0d, required 1", ch_a);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt_a;
    sel = 1'b0;
    tx  = 1'b0;
    idle(5);
    tx  = 1'b1;
    idle(60);
    total++;
    if (fe_cnt_a != fe0) $display("FAIL glitch_frame_err: got %0d, required %0d", fe_cnt_a, fe0);
    else pass_cnt++;
    total++;
    if ({on_a, ch_a, note_a, vel_a, led_a} !== last_a)
      $display("FAIL glitch_outputs: got %h, required %h", {on_a, ch_a, note_a, vel_a, led_a}, last_a);
    else pass_cnt++;
    push(0, 1, 4'd1, 7'h41, 7'h22);
    send_byte(0, 8'h41, 1, -1);
    send_byte(0, 8'h22, 1, -1);
    idle(40);
    total++;
    if (qa.size() != 0) $display("FAIL glitch_running_missing: got %0d pending, required 0", qa.size());
    else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt_a;
    send_byte(0, 8'h55, 0, -1);
    idle(20);
    total++;
    if (fe_cnt_a - fe0 != 1) $display("FAIL frame_err_pulse: got %0d cycles, required 1", fe_cnt_a - fe0);
    else pass_cnt++;
    send_byte(0, 8'h45, 1, -1);
    send_byte(0, 8'h10, 1, -1);
    idle(40);
    total++;
    if (note_a !== last_a.note) $display("FAIL frame_err_drop: got note %h, required %h", note_a, last_a.note);
    else pass_cnt++;
    total++;
    if (ec_a !== EXP_EC) $display("FAIL err_count: got %0d, required %0d", ec_a, EXP_EC);
    else pass_cnt++;
  endtask

  task automatic test_filter();
    send_byte(1, 8'h92, 1, -1);
    send_byte(1, 8'h30, 1, -1);
    send_byte(1, 8'h30, 1, -1);
    idle(40);
    push(1, 1, 4'd3, 7'h30, 7'h30);
    send_byte(1, 8'h93, 1, -1);
    send_byte(1, 8'h30, 1, -1);
    send_byte(1, 8'h30, 1, -1);
    idle(40);
    total++;
    if (qb.size() != 0) $display("FAIL filter_missing: got %0d pending, required 0", qb.size());
    else pass_cnt++;
    total++;
    if (led_b !== 8'hB0) $display("FAIL filter_led: got %h, required b0", led_b);
    else pass_cnt++;
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_byte(0, 8'h90, 1, -1);
    send_byte(0, 8'h3C, 1, 4);
    rst = 1'b1;
    tick();
    total++;
    if ({mv_a, on_a, ch_a, note_a, vel_a, fe_a, led_a, ec_a} !== 38'd0)
      $display("FAIL reset_mid: got %h, required 0", {mv_a, on_a, ch_a, note_a, vel_a, fe_a, led_a, ec_a});
    else pass_cnt++;
    tx = 1'b1;
    idle(2);
    rst = 1'b0;
    led_m_a = 8'd0;
    idle(30);
    send_byte(0, 8'h3C, 1, -1);
    send_byte(0, 8'h64, 1, -1);
    idle(40);
    total++;
    if (led_a !== 8'h00) $display("FAIL reset_rs_cleared: got led %h, required 00", led_a);
    else pass_cnt++;
    push(0, 1, 4'd0, 7'h3C, 7'h64);
    send_byte(0, 8'h90, 1, -1);
    send_byte(0, 8'h3C, 1, -1);
    send_byte(0, 8'h64, 1, -1);
    idle(40);
    total++;
    if (qa.size() != 0) $display("FAIL reset_recover_missing: got %0d pending, required 0", qa.size());
    else pass_cnt++;
    total++;
    if (led_a !== 8'hBC) $display("FAIL reset_recover_led: got %h, required bc", led_a);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_glitch();
    test_frame_err();
    test_filter();
    test_reset_mid();
    idle(10);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
